id_r_pipe: RTL and testbench

//  Registered, multi-lane decoder for R-type SPECIAL/SPECIAL2 instructions, with a ready/valid handshake
//  and a 2-entry skid buffer. Sits between fetch and the issue stage.

---
 rtl/id_r_pipe.sv | 217 +++++++++++++++++++++
 tb/tb_id_r_pipe.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/id_r_pipe.sv
// id_r_pipe: registered multi-lane SPECIAL/SPECIAL2 R-type decoder with ready/valid handshake
// and a 2-entry skid buffer (main register M drives the outputs, skid register S absorbs stalls).
module id_r_pipe #(
    parameter int LANES       = 1,
    parameter int INST_W      = 8,
    parameter bit SPECIAL2_EN = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LANES-1:0]          in_lane_vld,
    input  logic [32*LANES-1:0]       inst_code,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LANES-1:0]          out_lane_vld,
    output logic [INST_W*LANES-1:0]   inst,
    output logic [5*LANES-1:0]        reg_s,
    output logic [5*LANES-1:0]        reg_t,
    output logic [5*LANES-1:0]        reg_d,
    output logic [5*LANES-1:0]        shift,
    output logic [LANES-1:0]          is_jump,
    output logic [LANES-1:0]          is_trap,
    output logic [LANES-1:0]          uses_hilo,
    output logic [LANES-1:0]          wr_rd,
    output logic [LANES-1:0]          illegal
);
    localparam int CODE_W = 6;
    localparam logic [CODE_W-1:0] INST_SLL     = 6'd1;
    localparam logic [CODE_W-1:0] INST_SRL     = 6'd2;
    localparam logic [CODE_W-1:0] INST_SRA     = 6'd3;
    localparam logic [CODE_W-1:0] INST_SLLV    = 6'd4;
    localparam logic [CODE_W-1:0] INST_SRLV    = 6'd5;
    localparam logic [CODE_W-1:0] INST_SRAV    = 6'd6;
    localparam logic [CODE_W-1:0] INST_JR      = 6'd7;
    localparam logic [CODE_W-1:0] INST_JALR    = 6'd8;
    localparam logic [CODE_W-1:0] INST_MOVZ    = 6'd9;
    localparam logic [CODE_W-1:0] INST_MOVN    = 6'd10;
    localparam logic [CODE_W-1:0] INST_SYSCALL = 6'd11;
    localparam logic [CODE_W-1:0] INST_BREAK   = 6'd12;
    localparam logic [CODE_W-1:0] INST_MFHI    = 6'd13;
    localparam logic [CODE_W-1:0] INST_MTHI    = 6'd14;
    localparam logic [CODE_W-1:0] INST_MFLO    = 6'd15;
    localparam logic [CODE_W-1:0] INST_MTLO    = 6'd16;
    localparam logic [CODE_W-1:0] INST_MULT    = 6'd17;
    localparam logic [CODE_W-1:0] INST_MULTU   = 6'd18;
    localparam logic [CODE_W-1:0] INST_DIV     = 6'd19;
    localparam logic [CODE_W-1:0] INST_DIVU    = 6'd20;
    localparam logic [CODE_W-1:0] INST_ADD     = 6'd21;
    localparam logic [CODE_W-1:0] INST_ADDU    = 6'd22;
    localparam logic [CODE_W-1:0] INST_SUB     = 6'd23;
    localparam logic [CODE_W-1:0] INST_SUBU    = 6'd24;
    localparam logic [CODE_W-1:0] INST_AND     = 6'd25;
    localparam logic [CODE_W-1:0] INST_OR      = 6'd26;
    localparam logic [CODE_W-1:0] INST_XOR     = 6'd27;
    localparam logic [CODE_W-1:0] INST_NOR     = 6'd28;
    localparam logic [CODE_W-1:0] INST_SLT     = 6'd29;
    localparam logic [CODE_W-1:0] INST_SLTU    = 6'd30;
    localparam logic [CODE_W-1:0] INST_MADD    = 6'd31;
    localparam logic [CODE_W-1:0] INST_MADDU   = 6'd32;
    localparam logic [CODE_W-1:0] INST_MUL     = 6'd33;
    localparam logic [CODE_W-1:0] INST_MSUB    = 6'd34;
    localparam logic [CODE_W-1:0] INST_MSUBU   = 6'd35;
    localparam logic [CODE_W-1:0] INST_CLZ     = 6'd36;
    localparam logic [CODE_W-1:0] INST_CLO     = 6'd37;
    localparam logic [CODE_W-1:0] INST_INVALID = 6'd63;

    // One stored lane: {lane_vld, inst, rs, rt, rd, sa, jump, trap, hilo, wr_rd, illegal}
    localparam int ENT_W = INST_W + 26;

    if (INST_W < CODE_W || LANES < 1 || LANES > 4) begin : g_cfg_err
        $error("id_r_pipe: INST_W must be >= 6 and LANES must be 1..4");
    end

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    state_t                   r_state;
    state_t                   w_nxt;
    logic [LANES*ENT_W-1:0]   r_m;
    logic [LANES*ENT_W-1:0]   r_s;
    logic [LANES*ENT_W-1:0]   w_dec;
    logic                     w_in_fire;
    logic                     w_out_fire;
    logic                     w_ld_m;
    logic                     w_m_from_s;
    logic                     w_ld_s;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic [31:0]       w_word;
        logic [5:0]        w_op;
        logic [5:0]        w_fn;
        logic [CODE_W-1:0] w_raw;
        logic [CODE_W-1:0] w_c;
        logic              w_ok;
        logic              w_jump;
        logic              w_trap;
        logic              w_hilo;
        logic              w_wr;
        logic              w_ill;
        assign w_word = inst_code[g*32 +: 32];
        assign w_op   = w_word[31:26];
        assign w_fn   = w_word[5:0];
        assign w_ok   = in_lane_vld[g];
        always_comb begin
            w_raw = INST_INVALID;
            if (w_op == 6'h00) begin
                case (w_fn)
                    6'h00: w_raw = INST_SLL;
                    6'h02: w_raw = INST_SRL;
                    6'h03: w_raw = INST_SRA;
                    6'h04: w_raw = INST_SLLV;
                    6'h06: w_raw = INST_SRLV;
                    6'h07: w_raw = INST_SRAV;
                    6'h08: w_raw = INST_JR;
                    6'h09: w_raw = INST_JALR;
                    6'h0a: w_raw = INST_MOVZ;
                    6'h0b: w_raw = INST_MOVN;
                    6'h0c: w_raw = INST_SYSCALL;
                    6'h0d: w_raw = INST_BREAK;
                    6'h10: w_raw = INST_MFHI;
                    6'h11: w_raw = INST_MTHI;
                    6'h12: w_raw = INST_MFLO;
                    6'h13: w_raw = INST_MTLO;
                    6'h18: w_raw = INST_MULT;
                    6'h19: w_raw = INST_MULTU;
                    6'h1a: w_raw = INST_DIV;
                    6'h1b: w_raw = INST_DIVU;
                    6'h20: w_raw = INST_ADD;
                    6'h21: w_raw = INST_ADDU;
                    6'h22: w_raw = INST_SUB;
                    6'h23: w_raw = INST_SUBU;
                    6'h24: w_raw = INST_AND;
                    6'h25: w_raw = INST_OR;
                    6'h26: w_raw = INST_XOR;
                    6'h27: w_raw = INST_NOR;
                    6'h2a: w_raw = INST_SLT;
                    6'h2b: w_raw = INST_SLTU;
                    default: w_raw = INST_INVALID;
                endcase
            end else if (w_op == 6'h1c && SPECIAL2_EN) begin
                case (w_fn)
                    6'h00: w_raw = INST_MADD;
                    6'h01: w_raw = INST_MADDU;
                    6'h02: w_raw = INST_MUL;
                    6'h04: w_raw = INST_MSUB;
                    6'h05: w_raw = INST_MSUBU;
                    6'h20: w_raw = INST_CLZ;
                    6'h21: w_raw = INST_CLO;
                    default: w_raw = INST_INVALID;
                endcase
            end
        end
        // Flags come from the decoded code only; an invalid lane decodes INVALID and so raises none
        assign w_c    = w_ok ? w_raw : INST_INVALID;
        assign w_jump = w_c inside {INST_JR, INST_JALR};
        assign w_trap = w_c inside {INST_SYSCALL, INST_BREAK};
        assign w_hilo = w_c inside {INST_MFHI, INST_MFLO, INST_MTHI, INST_MTLO, INST_MULT, INST_MULTU,
                                    INST_DIV, INST_DIVU, INST_MADD, INST_MADDU, INST_MSUB, INST_MSUBU};
        assign w_wr   = w_c inside {INST_SLL, INST_SRL, INST_SRA, INST_SLLV, INST_SRLV, INST_SRAV,
                                    INST_MOVZ, INST_MOVN, INST_MFHI, INST_MFLO, INST_ADD, INST_ADDU,
                                    INST_SUB, INST_SUBU, INST_AND, INST_OR, INST_XOR, INST_NOR,
                                    INST_SLT, INST_SLTU, INST_JALR, INST_MUL, INST_CLZ, INST_CLO};
        assign w_ill  = w_ok && w_c == INST_INVALID;
        assign w_dec[g*ENT_W +: ENT_W] = {w_ok, INST_W'(w_c), w_word[25:6], w_jump, w_trap, w_hilo, w_wr, w_ill};
        assign {out_lane_vld[g], inst[g*INST_W +: INST_W], reg_s[g*5 +: 5], reg_t[g*5 +: 5],
                reg_d[g*5 +: 5], shift[g*5 +: 5], is_jump[g], is_trap[g], uses_hilo[g], wr_rd[g],
                illegal[g]} = r_m[g*ENT_W +: ENT_W];
    end

    assign in_ready   = r_state != TWO;
    assign out_valid  = r_state != EMPTY;
    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = out_valid && out_ready;

    always_comb begin
        w_nxt      = r_state;
        w_ld_m     = 1'b0;
        w_m_from_s = 1'b0;
        w_ld_s     = 1'b0;
        case (r_state)
            EMPTY: begin
                w_ld_m = w_in_fire;
                w_nxt  = w_in_fire ? ONE : EMPTY;
            end
            ONE: begin
                w_ld_m = w_in_fire && w_out_fire;
                w_ld_s = w_in_fire && !w_out_fire;
                w_nxt  = w_ld_s ? TWO : (!w_in_fire && w_out_fire) ? EMPTY : ONE;
            end
            TWO: begin
                w_ld_m     = w_out_fire;
                w_m_from_s = w_out_fire;
                w_nxt      = w_out_fire ? ONE : TWO;
            end
            default: w_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= EMPTY;
            r_m     <= '0;
            r_s     <= '0;
        end else if (flush) begin
            r_state <= EMPTY;
            r_m     <= '0;
            r_s     <= '0;
        end else begin
            r_state <= w_nxt;
            if (w_ld_m)
                r_m <= w_m_from_s ? r_s : w_dec;
            if (w_ld_s)
                r_s <= w_dec;
        end
    end
endmodule

// File: tb/tb_id_r_pipe.sv
// tb_id_r_pipe: scoreboard bench; a 2-lane decoder with SPECIAL2 on and a 1-lane one with SPECIAL2 off
// share the same stimulus and are checked against a table-driven reference model.
module tb_id_r_pipe;
    localparam int C_JR = 7, C_SYSCALL = 11, C_ADDU = 22, C_MUL = 33, C_INV = 63;

    typedef struct packed {
        logic [7:0] inst;
        logic [4:0] s, t, d, sh;
        logic       j, tr, h, w, il;
    } lane_t;
    typedef struct {
        lane_t      l0, l1, n0;
        logic [1:0] vld;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, out_ready, mon_en;
    logic [1:0]  lv;
    logic [63:0] code;
    logic        in_ready, out_valid;
    logic [1:0]  out_lane_vld, is_jump, is_trap, uses_hilo, wr_rd, illegal;
    logic [15:0] inst;
    logic [9:0]  reg_s, reg_t, reg_d, shift;
    logic        n_in_ready, n_out_valid, n_lane_vld, n_jump, n_trap, n_hilo, n_wr, n_ill;
    logic [7:0]  n_inst;
    logic [4:0]  n_s, n_t, n_d, n_sh;

    int   tests = 0, fails = 0;
    int   sp[64], s2[64];
    exp_t q[$];

    id_r_pipe #(.LANES(2), .INST_W(8), .SPECIAL2_EN(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_lane_vld(lv), .inst_code(code), .out_valid(out_valid), .out_ready(out_ready),
        .out_lane_vld(out_lane_vld), .inst(inst), .reg_s(reg_s), .reg_t(reg_t), .reg_d(reg_d),
        .shift(shift), .is_jump(is_jump), .is_trap(is_trap), .uses_hilo(uses_hilo), .wr_rd(wr_rd),
        .illegal(illegal));

    id_r_pipe #(.LANES(1), .INST_W(8), .SPECIAL2_EN(1'b0)) u_nos2 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(n_in_ready),
        .in_lane_vld(lv[0]), .inst_code(code[31:0]), .out_valid(n_out_valid), .out_ready(out_ready),
        .out_lane_vld(n_lane_vld), .inst(n_inst), .reg_s(n_s), .reg_t(n_t), .reg_d(n_d),
        .shift(n_sh), .is_jump(n_jump), .is_trap(n_trap), .uses_hilo(n_hilo), .wr_rd(n_wr),
        .illegal(n_ill));

    always #5 clk = ~clk;

    task automatic chk(string nm, logic [63:0] got, logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    // Reference decode: funct tables plus instruction-class membership by code
    function automatic lane_t model(logic [31:0] w, logic v, bit s2en);
        lane_t r;
        int    c;
        c = !v ? C_INV : w[31:26] == 6'h00 ? sp[w[5:0]] :
            (w[31:26] == 6'h1c && s2en) ? s2[w[5:0]] : C_INV;
        r.inst = 8'(c);
        r.s    = w[25:21];
        r.t    = w[20:16];
        r.d    = w[15:11];
        r.sh   = w[10:6];
        r.j    = c inside {7, 8};
        r.tr   = c inside {11, 12};
        r.h    = c inside {[13:20], 31, 32, 34, 35};
        r.w    = c inside {[1:6], 8, 9, 10, 13, 15, [21:30], 33, 36, 37};
        r.il   = v && c == C_INV;
        return r;
    endfunction

    function automatic exp_t mk(logic [1:0] l, logic [63:0] c);
        exp_t e;
        e.vld = l;
        e.l0  = model(c[31:0], l[0], 1'b1);
        e.l1  = model(c[63:32], l[1], 1'b1);
        e.n0  = model(c[31:0], l[0], 1'b0);
        return e;
    endfunction

    function automatic lane_t got_lane(int i);
        return {inst[i*8 +: 8], reg_s[i*5 +: 5], reg_t[i*5 +: 5], reg_d[i*5 +: 5], shift[i*5 +: 5],
                is_jump[i], is_trap[i], uses_hilo[i], wr_rd[i], illegal[i]};
    endfunction

    function automatic lane_t got_n();
        return {n_inst, n_s, n_t, n_d, n_sh, n_jump, n_trap, n_hilo, n_wr, n_ill};
    endfunction

    // Monitor: occupancy-derived handshake expectations and in-order payload checks
    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
            chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
            chk("n_out_valid", 64'(n_out_valid), 64'(q.size() != 0));
            if (out_valid && q.size() != 0) begin
                chk("lane_vld", 64'(out_lane_vld), 64'(q[0].vld));
                chk("lane0", 64'(got_lane(0)), 64'(q[0].l0));
                chk("lane1", 64'(got_lane(1)), 64'(q[0].l1));
                chk("nos2_lane0", 64'({n_lane_vld, got_n()}), 64'({q[0].vld[0], q[0].n0}));
                if (out_ready)
                    void'(q.pop_front());
            end
        end
    end

    task automatic cyc(logic v, logic [1:0] l, logic [63:0] c, logic ordy, logic fl);
        @(posedge clk);
        #1;
        in_valid  = v;
        lv        = l;
        code      = c;
        out_ready = ordy && !fl;
        flush     = fl;
        @(negedge clk);
        #1;
        if (fl)
            q.delete();
        else if (v && in_ready)
            q.push_back(mk(l, c));
    endtask

    function automatic logic [31:0] rnd_word();
        logic [31:0] w;
        int          k;
        w = $urandom;
        k = $urandom_range(0, 3);
        if (k < 2)
            w[31:26] = 6'h00;
        else if (k == 2)
            w[31:26] = 6'h1c;
        return w;
    endfunction

    initial begin
        byte sp_f[30] = '{8'h00, 8'h02, 8'h03, 8'h04, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0a, 8'h0b,
                          8'h0c, 8'h0d, 8'h10, 8'h11, 8'h12, 8'h13, 8'h18, 8'h19, 8'h1a, 8'h1b,
                          8'h20, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27, 8'h2a, 8'h2b};
        byte s2_f[7]  = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h05, 8'h20, 8'h21};
        foreach (sp[i]) begin
            sp[i] = C_INV;
            s2[i] = C_INV;
        end
        foreach (sp_f[i]) sp[sp_f[i]] = i + 1;
        foreach (s2_f[i]) s2[s2_f[i]] = i + 31;
        mon_en = 1'b0; rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        lv = 2'b00; code = 64'h0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_outputs", 64'(got_lane(0)) | 64'(got_lane(1)) | 64'(got_n()), 64'd0);
        #1 rst_n = 1'b1;
        mon_en = 1'b1;
        cyc(0, 2'b00, 64'h0, 1, 0);
        cyc(0, 2'b00, 64'h0, 1, 0);
        chk("idle_inst", 64'(inst), 64'd0);

        cyc(1, 2'b01, 64'h00221821, 1, 0);
        cyc(0, 2'b00, 64'h0, 1, 0);
        chk("addu_code", 64'(inst[7:0]), C_ADDU);
        chk("addu_fields", 64'({reg_s[4:0], reg_t[4:0], reg_d[4:0], wr_rd[0], illegal[0]}),
            64'({5'd1, 5'd2, 5'd3, 1'b1, 1'b0}));
        cyc(0, 2'b00, 64'h0, 1, 0);
        chk("addu_drop", 64'(out_valid), 64'd0);

        cyc(1, 2'b01, 64'h00221821, 0, 0);
        cyc(1, 2'b01, 64'h0000000c, 0, 0);
        cyc(0, 2'b00, 64'h0, 0, 0);
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        cyc(0, 2'b00, 64'h0, 1, 0);
        chk("bp_first", 64'(inst[7:0]), C_ADDU);
        cyc(0, 2'b00, 64'h0, 1, 0);
        chk("bp_second", 64'({inst[7:0], is_trap[0]}), 64'({8'(C_SYSCALL), 1'b1}));

        cyc(1, 2'b01, 64'h00221821, 0, 0);
        cyc(1, 2'b01, 64'h0000000c, 0, 0);
        cyc(1, 2'b11, 64'h00430820_00221826, 1, 1);
        cyc(0, 2'b00, 64'h0, 1, 0);
        chk("flush_two", 64'({out_valid, inst}), 64'd0);
        cyc(1, 2'b01, 64'h00221821, 0, 0);
        cyc(1, 2'b01, 64'h00221826, 1, 1);
        cyc(0, 2'b00, 64'h0, 1, 0);
        chk("flush_one", 64'({out_valid, inst}), 64'd0);

        cyc(1, 2'b01, 64'h70a62002, 1, 0);
        cyc(0, 2'b00, 64'h0, 1, 0);
        chk("mul_s2on", 64'({inst[7:0], wr_rd[0], reg_d[4:0]}), 64'({8'(C_MUL), 1'b1, 5'd4}));
        chk("mul_s2off", 64'({n_inst, n_ill}), 64'({8'(C_INV), 1'b1}));

        cyc(1, 2'b10, 64'h00000008_deadbeef, 1, 0);
        cyc(0, 2'b00, 64'h0, 1, 0);
        chk("vld_lane0", 64'({inst[7:0], illegal[0]}), 64'({8'(C_INV), 1'b0}));
        chk("jr_lane1", 64'({inst[15:8], is_jump[1]}), 64'({8'(C_JR), 1'b1}));

        for (int i = 0; i < 3000; i++)
            cyc($urandom_range(0, 3) != 0, 2'($urandom), {rnd_word(), rnd_word()},
                $urandom_range(0, 2) != 0, $urandom_range(0, 49) == 0);
        repeat (4) cyc(0, 2'b00, 64'h0, 1, 0);
        chk("drain_empty", 64'(q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
